// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-requester round-robin arbiter in front of a single-port synchronous SRAM
//
// Purpose: serialises read and write requests onto one SRAM port. When both
// requests are pending, the transaction type not granted last wins. All
// strobes, done pulses and busy are decoded from the state register only.
//
// Ports:
//   clk, n_rst                        clock, asynchronous active-low reset
//   i_rd_req, i_rd_addr               read request (level) and address
//   i_wr_req, i_wr_addr, i_wr_data    write request (level), address, data
//   i_sram_rdata                      SRAM read data, valid RD_LAT cycles after the strobe
//   o_sram_addr, o_sram_wdata         SRAM address / write data registers
//   o_sram_re, o_sram_we              SRAM read / write strobes
//   o_rd_data, o_rd_done              captured read data, read-complete pulse
//   o_wr_done                         write-complete pulse
//   o_busy                            high whenever a transaction is in flight
module sram_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [DATA_W-1:0] i_sram_rdata,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_wdata,
    output logic              o_sram_re,
    output logic              o_sram_we,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_done,
    output logic              o_wr_done,
    output logic              o_busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        RD_DONE  = 3'd3,
        WR_ISSUE = 3'd4,
        WR_DONE  = 3'd5
    } state_t;

    localparam logic [3:0] LAT = 4'(RD_LAT);

    state_t            state_q, state_d;
    logic              last_wr_q, last_wr_d;   // 1: most recent grant was a write
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                // A read wins when it is alone, or on contention when the last grant was a write.
                if (i_rd_req && (!i_wr_req || last_wr_q)) begin
                    state_d   = RD_ISSUE;
                    last_wr_d = 1'b0;
                    cnt_d     = LAT;
                    addr_d    = i_rd_addr;
                end else if (i_wr_req) begin
                    state_d   = WR_ISSUE;
                    last_wr_d = 1'b1;
                    addr_d    = i_wr_addr;
                    wdata_d   = i_wr_data;
                end
            end
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT: begin
                // cnt_q == 1 marks the RD_LAT-th cycle after the strobe: data is valid now.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RD_DONE;
                    rdata_d = i_sram_rdata;
                end
            end
            RD_DONE:  state_d = IDLE;
            WR_ISSUE: state_d = WR_DONE;
            WR_DONE:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            last_wr_q <= 1'b1;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
        end
    end

    assign o_sram_addr  = addr_q;
    assign o_sram_wdata = wdata_q;
    assign o_rd_data    = rdata_q;
    assign o_sram_re    = (state_q == RD_ISSUE);
    assign o_sram_we    = (state_q == WR_ISSUE);
    assign o_rd_done    = (state_q == RD_DONE);
    assign o_wr_done    = (state_q == WR_DONE);
    assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard bench for sram_arbiter with a transaction-level reference model
module tb_sram_arbiter;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 2;

    typedef struct {
        bit          is_wr;
        logic [15:0] addr;
        logic [31:0] data;    // write data, or expected read data
        int          strobe;  // cycle of the SRAM strobe
        int          done;    // cycle of the done pulse
    } exp_t;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              i_rd_req, i_wr_req;
    logic [ADDR_W-1:0] i_rd_addr, i_wr_addr;
    logic [DATA_W-1:0] i_wr_data, i_sram_rdata;
    logic [ADDR_W-1:0] o_sram_addr;
    logic [DATA_W-1:0] o_sram_wdata, o_rd_data;
    logic              o_sram_re, o_sram_we, o_rd_done, o_wr_done, o_busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 0;

    // reference model state
    exp_t        exp_q[$];
    logic [31:0] ref_mem[16];
    bit          last_w;
    int          free_at;
    int          rd_st, wr_st;          // 0 idle, 1 waiting, 2 granted
    int          rd_done_at, wr_done_at;

    // SRAM model state
    logic [31:0] sram_mem[16];
    int          rd_due;
    logic [15:0] rd_due_addr;

    // monitor state
    exp_t        m_f;
    bit          m_have, m_srd, m_swr, m_drd, m_dwr, m_busy;
    logic [15:0] m_addr;
    logic [31:0] m_wdata, m_rd;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .n_rst(n_rst),
        .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr),
        .i_wr_req(i_wr_req), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
        .i_sram_rdata(i_sram_rdata),
        .o_sram_addr(o_sram_addr), .o_sram_wdata(o_sram_wdata),
        .o_sram_re(o_sram_re), .o_sram_we(o_sram_we),
        .o_rd_data(o_rd_data), .o_rd_done(o_rd_done), .o_wr_done(o_wr_done),
        .o_busy(o_busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, expv);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_addr"},  64'(o_sram_addr),  64'd0);
        chk({tag, "_wdata"}, 64'(o_sram_wdata), 64'd0);
        chk({tag, "_rdata"}, 64'(o_rd_data),    64'd0);
        chk({tag, "_re"},    64'(o_sram_re),    64'd0);
        chk({tag, "_we"},    64'(o_sram_we),    64'd0);
        chk({tag, "_rdone"}, 64'(o_rd_done),    64'd0);
        chk({tag, "_wdone"}, 64'(o_wr_done),    64'd0);
        chk({tag, "_busy"},  64'(o_busy),       64'd0);
    endtask

    // Advance one cycle; act as the SRAM for the cycle just entered.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (n_rst) begin
            if (o_sram_we) sram_mem[o_sram_addr[3:0]] = o_sram_wdata;
            if (o_sram_re) begin
                rd_due      = cyc + RD_LAT;
                rd_due_addr = o_sram_addr;
            end
        end
        i_sram_rdata = (cyc == rd_due) ? sram_mem[rd_due_addr[3:0]] : DATA_W'($urandom);
    endtask

    // Reference model: one transaction at a time, one IDLE cycle between them,
    // read occupies strobe + RD_LAT wait + done, write occupies strobe + done.
    task automatic commit();
        exp_t e;
        bit   g_rd;
        if (!n_rst || cyc < free_at || (!i_rd_req && !i_wr_req)) return;
        g_rd     = i_rd_req && (!i_wr_req || last_w);
        e.is_wr  = !g_rd;
        e.strobe = cyc + 1;
        if (g_rd) begin
            e.addr     = i_rd_addr;
            e.data     = ref_mem[i_rd_addr[3:0]];
            e.done     = cyc + 2 + RD_LAT;
            rd_st      = 2;
            rd_done_at = e.done;
        end else begin
            e.addr     = i_wr_addr;
            e.data     = i_wr_data;
            e.done     = cyc + 2;
            ref_mem[i_wr_addr[3:0]] = i_wr_data;
            wr_st      = 2;
            wr_done_at = e.done;
        end
        last_w  = !g_rd;
        free_at = e.done + 1;
        exp_q.push_back(e);
    endtask

    task automatic req_rd(input logic [15:0] a);
        i_rd_req = 1'b1; i_rd_addr = a; rd_st = 1;
    endtask

    task automatic req_wr(input logic [15:0] a, input logic [31:0] d);
        i_wr_req = 1'b1; i_wr_addr = a; i_wr_data = d; wr_st = 1;
    endtask

    task automatic drive_reqs(input int p_new, input int p_drop);
        if (rd_st == 2 && cyc > rd_done_at) begin rd_st = 0; i_rd_req = 1'b0; end
        if (wr_st == 2 && cyc > wr_done_at) begin wr_st = 0; i_wr_req = 1'b0; end
        if (rd_st == 2) begin
            i_rd_addr = 16'($urandom);
            if ($urandom_range(99) < p_drop) i_rd_req = 1'b0;
        end
        if (wr_st == 2) begin
            i_wr_addr = 16'($urandom);
            i_wr_data = $urandom;
            if ($urandom_range(99) < p_drop) i_wr_req = 1'b0;
        end
        if (rd_st == 0 && $urandom_range(99) < p_new) req_rd(16'($urandom));
        if (wr_st == 0 && $urandom_range(99) < p_new) req_wr(16'($urandom), $urandom);
    endtask

    task automatic run(input int n, input int p_new, input int p_drop);
        for (int i = 0; i < n; i++) begin
            step();
            drive_reqs(p_new, p_drop);
            commit();
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        last_w  = 1'b1;
        free_at = 0;
        rd_st = 0; wr_st = 0;
        i_rd_req = 1'b0; i_wr_req = 1'b0;
        rd_due = -1;
        m_addr = '0; m_wdata = '0; m_rd = '0;
    endtask

    task automatic async_reset(input string tag);
        #2 n_rst = 1'b0;
        mon_en = 1'b0;
        #1 check_zero(tag);
        model_reset();
        step();
        step();
        n_rst  = 1'b1;
        mon_en = 1'b1;
    endtask

    // Monitor: compares every observable output against the head of the expected queue.
    always @(negedge clk) begin
        if (mon_en) begin
            m_have = exp_q.size() > 0;
            if (m_have) m_f = exp_q[0];
            m_srd  = m_have && !m_f.is_wr && m_f.strobe == cyc;
            m_swr  = m_have &&  m_f.is_wr && m_f.strobe == cyc;
            m_drd  = m_have && !m_f.is_wr && m_f.done == cyc;
            m_dwr  = m_have &&  m_f.is_wr && m_f.done == cyc;
            m_busy = m_have && m_f.strobe <= cyc;
            if (m_srd || m_swr) m_addr = m_f.addr;
            if (m_swr) m_wdata = m_f.data;
            if (m_drd) m_rd = m_f.data;
            chk("re",      64'(o_sram_re),    64'(m_srd));
            chk("we",      64'(o_sram_we),    64'(m_swr));
            chk("re_we",   64'(o_sram_re & o_sram_we), 64'd0);
            chk("rd_done", 64'(o_rd_done),    64'(m_drd));
            chk("wr_done", 64'(o_wr_done),    64'(m_dwr));
            chk("busy",    64'(o_busy),       64'(m_busy));
            chk("addr",    64'(o_sram_addr),  64'(m_addr));
            chk("wdata",   64'(o_sram_wdata), 64'(m_wdata));
            chk("rd_data", 64'(o_rd_data),    64'(m_rd));
            if (m_drd || m_dwr) void'(exp_q.pop_front());
        end
    end

    initial begin
        logic [31:0] v;
        n_rst = 1'b0;
        i_rd_addr = '0; i_wr_addr = '0; i_wr_data = '0; i_sram_rdata = '0;
        model_reset();
        for (int i = 0; i < 16; i++) begin
            v = $urandom;
            sram_mem[i] = v;
            ref_mem[i]  = v;
        end
        sram_mem[0] = 32'hDEADBEEF;
        ref_mem[0]  = 32'hDEADBEEF;
        #3 check_zero("por");
        step();
        step();
        n_rst  = 1'b1;
        mon_en = 1'b1;

        // read only: re in cycle 1, done in cycle 4
        req_rd(16'h0010);
        commit();
        run(8, 0, 0);
        chk("rd_literal", 64'(o_rd_data), 64'h0000_0000_DEAD_BEEF);

        // write only: we in cycle 1, done in cycle 2
        step();
        req_wr(16'h0020, 32'h1234_5678);
        commit();
        run(5, 0, 0);

        // both held continuously from reset release
        async_reset("rst_idle");
        req_rd(16'h0003);
        req_wr(16'h0005, 32'hA5A5_0001);
        commit();
        run(24, 100, 0);
        run(20, 0, 0);

        // reset pulsed during RD_WAIT, then a fresh read
        step();
        req_rd(16'h0044);
        commit();
        step(); commit();
        step(); commit();
        async_reset("rst_wait");
        req_rd(16'h0044);
        commit();
        run(8, 0, 0);

        // read request dropped in the cycle after RD_ISSUE
        step();
        req_rd(16'h0107);
        commit();
        step(); commit();
        step();
        i_rd_req = 1'b0;
        commit();
        run(6, 0, 0);

        // write arrives while a read is in flight
        step();
        req_rd(16'h0209);
        commit();
        step(); commit();
        step();
        req_wr(16'h030A, 32'hCAFE_F00D);
        commit();
        run(12, 0, 0);

        // randomized traffic, including early request drops
        run(3000, 30, 10);
        run(40, 0, 0);
        chk("drain", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
